car_alarm_system_n: RTL
=======================

Name: car_alarm_system_n

Overview:
- Parametrised successor of the single-driver/single-passenger car alarm controller.
- Supports NUM_DOORS door sensors, with door 0 being the driver door.
- Timing windows are set by parameters, in seconds, derived from a prescaled Clk.
- Adds a siren-cycle limit with a silent-wait state, a sticky alarm-event flag and a debug state output.
- Top-level anti-theft block: drives siren, fuel-pump enable and dashboard status LED.

Parameters:
- NUM_DOORS, 2, number of door switches; bit 0 is the driver door.
- CLK_PER_SEC, 2, Clk cycles per one-second tick (>=1).
- TW, 4, width of the seconds counter; must hold the largest T_*.
- T_ARM, 6, arming delay after the last door closes.
- T_DRIVER, 8, entry delay when the driver door triggers.
- T_PASSENGER, 15, entry delay when only passenger doors trigger.
- T_ALARM_ON, 10, length of one siren burst.
- MAX_SIREN_CYCLES, 3, maximum consecutive siren bursts (>=1).

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- System_reset  in  1  synchronous, active-high reset.
- Ignition_switch  in  1  1 = ignition on.
- Brake_depressed_switch  in  1  brake pedal pressed.
- Hidden_switch  in  1  concealed owner switch.
- Door  in  NUM_DOORS  1 = door open; bit 0 is the driver door.
- Fuel_pump_power  out  1  fuel pump enable (registered).
- Siren  out  1  siren drive (registered).
- Status_indicator  out  1  dashboard LED (registered).
- Alarm_event  out  1  sticky flag: siren has sounded since it was last cleared.
- State  out  3  current state encoding, for debug.

Behaviour:
- Reset:
  - Synchronous; on the next edge State=ARMED, the timer and prescaler are cleared, and Siren=0, Fuel_pump_power=0, Alarm_event=0, Status_indicator=1.
  - Reset mid-operation aborts any countdown or siren burst.
- State encoding: ARMED=0, TRIGGERED=1, SOUND=2, SILENT_WAIT=3, DISARMED=4, WAIT_OPEN=5, WAIT_CLOSE=6, ARM_DELAY=7.
- Timer:
  - Every entry into TRIGGERED, SOUND or ARM_DELAY (including re-entry) loads the seconds counter with T and clears the prescaler.
  - Expiry fires exactly T*CLK_PER_SEC cycles after the entry edge.
- Ignition priority: Ignition_switch=1 in any state → DISARMED next edge. This overrides door events and timer expiry.
- ARMED:
  - Status_indicator blinks: 1 for CLK_PER_SEC cycles, then 0 for CLK_PER_SEC cycles, starting at 1 on entry.
  - Any Door bit = 1 → TRIGGERED. The delay is T_DRIVER if Door[0]=1 (driver wins a tie), else T_PASSENGER.
- TRIGGERED:
  - Status_indicator=1.
  - Door changes are ignored.
  - Timer expiry → SOUND, with the siren-cycle counter set to 1.
- SOUND:
  - Siren=1, Status_indicator=1.
  - On entry, Alarm_event is set to 1.
  - On expiry:
    - If all doors are closed → ARMED.
    - Else if the cycle count < MAX_SIREN_CYCLES → re-enter SOUND and increment the count.
    - Else → SILENT_WAIT.
- SILENT_WAIT:
  - Siren=0, Status_indicator=1.
  - All doors closed → ARMED.
- DISARMED:
  - Status_indicator=0.
  - Fuel_pump_power is set when Hidden_switch & Brake_depressed_switch are both 1 in the same cycle, visible one cycle later. It then stays 1 while in DISARMED.
  - Hidden_switch=1 clears Alarm_event.
  - Ignition off → WAIT_OPEN, and Fuel_pump_power clears on that same edge.
- WAIT_OPEN: any door open → WAIT_CLOSE.
- WAIT_CLOSE: all doors closed → ARM_DELAY.
- ARM_DELAY:
  - Any door open → WAIT_CLOSE; this beats a simultaneous expiry.
  - Expiry → ARMED.
- Siren and Fuel_pump_power are 0 in every state other than the ones stated above.

Decomposition:
- car_alarm_pkg holds:
  - the 3-bit state encoding constants;
  - default timing constants;
  - the door index constant DRIVER_DOOR=0.
- Sub-module cas_timer:
  - prescaler plus TW-bit down-counter;
  - inputs load and value[TW-1:0];
  - outputs tick (one-second pulse) and expired.
  - The same tick drives the ARMED blink.

Test Plan (defaults, CLK_PER_SEC=2):
1. Reset, then idle with doors closed → State=0, Siren=0, Fuel_pump_power=0; Status_indicator pattern 1,1,0,0,1,1… per cycle.
2. Ignition_switch=1, then Hidden_switch=Brake_depressed_switch=1 for 1 cycle → State=4; Fuel_pump_power=1 one cycle later and held. Ignition off → Fuel_pump_power=0 and State=5.
3. Ignition off, pulse Door[0] open/closed → WAIT_CLOSE, then ARM_DELAY, then ARMED after 12 cycles. Reopen Door[1] at cycle 6 → State=6; after close, a fresh 12-cycle countdown.
4. In ARMED:
   - Door[0]=1 → Siren=1 exactly 16 cycles after TRIGGERED entry.
   - Door[1] only → 30 cycles.
   - Door[0] plus ignition on at cycle 10 → State=4, Siren never asserts.
5. Door[1] held open → three 20-cycle siren bursts (Siren=1 for 60 cycles), then State=3 with Siren=0. Close the door → ARMED with Alarm_event=1. Ignition on plus Hidden_switch → Alarm_event=0.
6. System_reset=1 mid-SOUND → next edge State=0, Siren=0, Alarm_event=0, Status_indicator=1.

Source files
------------

// File: rtl/car_alarm_pkg.sv
// Shared definitions for the parametrised car alarm controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package car_alarm_pkg;

    // State encoding is visible on the debug State port, so the values are fixed.
    typedef enum logic [2:0] {
        ST_ARMED       = 3'd0,
        ST_TRIGGERED   = 3'd1,
        ST_SOUND       = 3'd2,
        ST_SILENT_WAIT = 3'd3,
        ST_DISARMED    = 3'd4,
        ST_WAIT_OPEN   = 3'd5,
        ST_WAIT_CLOSE  = 3'd6,
        ST_ARM_DELAY   = 3'd7
    } state_t;

    // Default build parameters; timing values are in one-second ticks.
    localparam int DEF_NUM_DOORS        = 2;
    localparam int DEF_CLK_PER_SEC      = 2;
    localparam int DEF_TW               = 4;
    localparam int DEF_T_ARM            = 6;
    localparam int DEF_T_DRIVER         = 8;
    localparam int DEF_T_PASSENGER      = 15;
    localparam int DEF_T_ALARM_ON       = 10;
    localparam int DEF_MAX_SIREN_CYCLES = 3;

    // Door bit that selects the shorter driver entry delay.
    localparam int DRIVER_DOOR = 0;

    // Width of a counter that must hold the values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cas_timer.sv
// Seconds timer: prescaler producing a one-second tick plus a TW-bit down-counter.
// Latency: expired is combinational and fires in the last cycle of value*CLK_PER_SEC after load.
// Backpressure: none; load restarts the countdown unconditionally.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   load, value   restart: counter <= value, prescaler <= 0
//   tick          high in the last cycle of each second (prescaler wrap)
//   expired       high in the cycle whose tick takes the counter from 1 to 0
module cas_timer #(
    parameter int CLK_PER_SEC = 2,
    parameter int TW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          tick,
    output logic          expired
);

    localparam int            PW      = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] pre;
    logic [TW-1:0] cnt;

    assign tick    = (pre == PRE_MAX);
    // Expiry lands exactly value*CLK_PER_SEC cycles after the load edge.
    assign expired = tick && (cnt == TW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
            cnt <= '0;
        end else if (load) begin
            pre <= '0;
            cnt <= value;
        end else if (tick) begin
            pre <= '0;
            // Saturate so an idle timer never wraps into a fresh expiry.
            if (cnt != '0) begin
                cnt <= cnt - TW'(1);
            end
        end else begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/car_alarm_system_n.sv
// Anti-theft controller: door-triggered siren with bursts limit, ignition disarm, fuel-pump interlock.
// Latency: all outputs registered; they reflect the state entered on the same edge.
// Backpressure: none; inputs are level-sampled every Clk edge.
//
// Ports:
//   Clk, System_reset        rising-edge clock, synchronous active-high reset
//   Ignition_switch          1 = ignition on; forces DISARMED from any state
//   Brake_depressed_switch   brake pedal, combined with Hidden_switch to enable the fuel pump
//   Hidden_switch            concealed owner switch; also clears Alarm_event while disarmed
//   Door[NUM_DOORS-1:0]      1 = door open; bit 0 is the driver door
//   Fuel_pump_power          fuel pump enable
//   Siren                    siren drive
//   Status_indicator         dashboard LED (blinks while armed)
//   Alarm_event              sticky: siren has sounded since last cleared
//   State                    current state encoding for debug
module car_alarm_system_n
    import car_alarm_pkg::*;
#(
    parameter int NUM_DOORS        = DEF_NUM_DOORS,
    parameter int CLK_PER_SEC      = DEF_CLK_PER_SEC,
    parameter int TW               = DEF_TW,
    parameter int T_ARM            = DEF_T_ARM,
    parameter int T_DRIVER         = DEF_T_DRIVER,
    parameter int T_PASSENGER      = DEF_T_PASSENGER,
    parameter int T_ALARM_ON       = DEF_T_ALARM_ON,
    parameter int MAX_SIREN_CYCLES = DEF_MAX_SIREN_CYCLES
) (
    input  logic                 Clk,
    input  logic                 System_reset,
    input  logic                 Ignition_switch,
    input  logic                 Brake_depressed_switch,
    input  logic                 Hidden_switch,
    input  logic [NUM_DOORS-1:0] Door,
    output logic                 Fuel_pump_power,
    output logic                 Siren,
    output logic                 Status_indicator,
    output logic                 Alarm_event,
    output logic [2:0]           State
);

    localparam int            CW            = cnt_width(MAX_SIREN_CYCLES);
    localparam logic [CW-1:0] MAX_CYC       = CW'(MAX_SIREN_CYCLES);
    localparam logic [TW-1:0] T_ARM_V       = TW'(T_ARM);
    localparam logic [TW-1:0] T_DRIVER_V    = TW'(T_DRIVER);
    localparam logic [TW-1:0] T_PASSENGER_V = TW'(T_PASSENGER);
    localparam logic [TW-1:0] T_ALARM_V     = TW'(T_ALARM_ON);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cyc;
    logic [CW-1:0] cyc_nx;
    logic          load;
    logic          reenter;
    logic [TW-1:0] load_val;
    logic          tick;
    logic          expired;
    logic          any_open;
    logic          status_nx;

    assign any_open = |Door;
    assign State    = state;

    cas_timer #(
        .CLK_PER_SEC (CLK_PER_SEC),
        .TW          (TW)
    ) u_timer (
        .clk     (Clk),
        .reset   (System_reset),
        .load    (load),
        .value   (load_val),
        .tick    (tick),
        .expired (expired)
    );

    always_comb begin
        state_nx  = state;
        cyc_nx    = cyc;
        load_val  = '0;
        reenter   = 1'b0;
        status_nx = 1'b0;

        if (Ignition_switch) begin
            state_nx = ST_DISARMED;
        end else begin
            unique case (state)
                ST_ARMED: begin
                    if (any_open) begin
                        state_nx = ST_TRIGGERED;
                        load_val = Door[DRIVER_DOOR] ? T_DRIVER_V : T_PASSENGER_V;
                    end
                end
                ST_TRIGGERED: begin
                    if (expired) begin
                        state_nx = ST_SOUND;
                        cyc_nx   = CW'(1);
                        load_val = T_ALARM_V;
                    end
                end
                ST_SOUND: begin
                    if (expired) begin
                        if (!any_open) begin
                            state_nx = ST_ARMED;
                        end else if (cyc < MAX_CYC) begin
                            state_nx = ST_SOUND;
                            reenter  = 1'b1;
                            cyc_nx   = cyc + CW'(1);
                            load_val = T_ALARM_V;
                        end else begin
                            state_nx = ST_SILENT_WAIT;
                        end
                    end
                end
                ST_SILENT_WAIT: begin
                    if (!any_open) begin
                        state_nx = ST_ARMED;
                    end
                end
                ST_DISARMED: begin
                    state_nx = ST_WAIT_OPEN;
                end
                ST_WAIT_OPEN: begin
                    if (any_open) begin
                        state_nx = ST_WAIT_CLOSE;
                    end
                end
                ST_WAIT_CLOSE: begin
                    if (!any_open) begin
                        state_nx = ST_ARM_DELAY;
                        load_val = T_ARM_V;
                    end
                end
                ST_ARM_DELAY: begin
                    // An opening door wins over an expiry in the same cycle.
                    if (any_open) begin
                        state_nx = ST_WAIT_CLOSE;
                    end else if (expired) begin
                        state_nx = ST_ARMED;
                    end
                end
                default: begin
                    state_nx = ST_ARMED;
                end
            endcase
        end

        // Restart the timer on every state change (this also phase-aligns the
        // ARMED blink to its entry) and on each new siren burst.
        load = reenter || (state_nx != state);

        unique case (state_nx)
            ST_ARMED: begin
                if (state == ST_ARMED) begin
                    status_nx = tick ? ~Status_indicator : Status_indicator;
                end else begin
                    status_nx = 1'b1;
                end
            end
            ST_TRIGGERED, ST_SOUND, ST_SILENT_WAIT: begin
                status_nx = 1'b1;
            end
            default: begin
                status_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (System_reset) begin
            state            <= ST_ARMED;
            cyc              <= '0;
            Siren            <= 1'b0;
            Fuel_pump_power  <= 1'b0;
            Alarm_event      <= 1'b0;
            Status_indicator <= 1'b1;
        end else begin
            state            <= state_nx;
            cyc              <= cyc_nx;
            Status_indicator <= status_nx;
            Siren            <= (state_nx == ST_SOUND);
            // Pump latches on Hidden&Brake while disarmed and drops on leaving.
            Fuel_pump_power  <= (state == ST_DISARMED) && (state_nx == ST_DISARMED) &&
                                (Fuel_pump_power || (Hidden_switch && Brake_depressed_switch));
            if (state_nx == ST_SOUND) begin
                Alarm_event <= 1'b1;
            end else if ((state == ST_DISARMED) && Hidden_switch) begin
                Alarm_event <= 1'b0;
            end
        end
    end

endmodule
